imm_decode_stage: RTL and testbench

//  Registered, parametrised RISC-V immediate decoder between fetch and decode.

---
 rtl/imm_decode_pkg.sv | 41 ++++
 rtl/imm_decode_stage_extract.sv | 74 +++++++
 rtl/imm_decode_stage.sv | 118 +++++++++++
 tb/tb_imm_decode_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the registered RISC-V immediate decoder.
// Entries are stored at the maximum supported widths so one struct type serves
// every XLEN/TAG_W configuration of the stage.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

  // Shift-amount encodings of OP-IMM / OP-IMM-32 are funct3 001 (SLLI) and 101 (SRLI/SRAI)
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode_stage_extract.sv
// Combinational immediate extraction: instruction word -> extended immediate and format.
// With IMM_DECODE_ILLEGAL_EN defined an illegal flag is also produced.
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
`ifdef IMM_DECODE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [31:0] raw;

  // Build the immediate as a 32-bit value already sign-extended to bit 31, then widen to XLEN
  always_comb begin
    raw = '0;
    fmt = FMT_NONE;
    unique case (inst[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt = FMT_I;
        raw = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP_IMM: begin
        if (is_shift(inst[14:12])) begin
          fmt = FMT_SHAMT;
          raw = {26'b0, ((XLEN == 64) ? inst[25] : 1'b0), inst[24:20]};
        end else begin
          fmt = FMT_I;
          raw = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_OP_IMM_32: begin
        if (is_shift(inst[14:12])) begin
          fmt = FMT_SHAMT;
          raw = {27'b0, inst[24:20]};
        end else begin
          fmt = FMT_I;
          raw = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        fmt = FMT_NONE;
        raw = '0;
      end
    endcase
  end

  assign imm = XLEN'($signed(raw));

`ifdef IMM_DECODE_ILLEGAL_EN
  assign illegal = (inst[1:0] != 2'b11) || (fmt == FMT_NONE);
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer (main + skid).
// Optional feature macro: IMM_DECODE_ILLEGAL_EN adds out_illegal and err_sticky.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
`ifdef IMM_DECODE_ILLEGAL_EN
  output logic             out_illegal,
  output logic             err_sticky,
`endif
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
    $error("imm_decode_stage: TAG_W out of range");
  end

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  imm_entry_t      new_entry, main_q, skid_q;
  logic            main_v, skid_v, ready_q;
  logic            accept, drain;
  logic            unused_bits;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic            dec_ill, main_ill, skid_ill, sticky_q;
`endif

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst    (in_inst),
`ifdef IMM_DECODE_ILLEGAL_EN
    .illegal (dec_ill),
`endif
    .imm     (dec_imm),
    .fmt     (dec_fmt)
  );

  assign new_entry = '{imm: IMM_MAX_W'(dec_imm), fmt: dec_fmt, tag: TAG_MAX_W'(in_tag)};
  assign accept    = in_valid && ready_q && !flush;
  assign drain     = main_v && out_ready;

  // Main/skid occupancy: new data goes to main when it is free or draining, else to skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef IMM_DECODE_ILLEGAL_EN
      main_ill <= 1'b0;
      skid_ill <= 1'b0;
`endif
    end else if (flush) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (accept && (drain || !main_v)) begin
      main_q   <= new_entry;
      main_v   <= 1'b1;
`ifdef IMM_DECODE_ILLEGAL_EN
      main_ill <= dec_ill;
`endif
    end else if (accept) begin
      skid_q   <= new_entry;
      skid_v   <= 1'b1;
      ready_q  <= 1'b0;
`ifdef IMM_DECODE_ILLEGAL_EN
      skid_ill <= dec_ill;
`endif
    end else if (drain) begin
      main_q   <= skid_q;
      main_v   <= skid_v;
      skid_v   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef IMM_DECODE_ILLEGAL_EN
      main_ill <= skid_ill;
`endif
    end
  end

`ifdef IMM_DECODE_ILLEGAL_EN
  // Sticky error survives flushes; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept && dec_ill) begin
      sticky_q <= 1'b1;
    end
  end

  assign out_illegal = main_ill;
  assign err_sticky  = sticky_q;
`endif

  assign in_ready    = ready_q;
  assign out_valid   = main_v;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_tag     = main_q.tag[TAG_W-1:0];
  assign unused_bits = ^{main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: one XLEN=32 and one XLEN=64 instance share the same stimulus.
// Expected results come from an arithmetic reference model and a FIFO scoreboard.
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  typedef struct {
    longint      imm64;
    logic [31:0] imm32;
    imm_fmt_e    fmt;
    bit          ill;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_tag32, out_tag64;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt32, out_fmt64;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic        out_illegal32, err_sticky32, out_illegal64, err_sticky64;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] drained[$];
  bit          last_acc;
  bit          sticky_exp;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
`ifdef IMM_DECODE_ILLEGAL_EN
    .out_illegal(out_illegal32), .err_sticky(err_sticky32),
`endif
    .out_tag(out_tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
`ifdef IMM_DECODE_ILLEGAL_EN
    .out_illegal(out_illegal64), .err_sticky(err_sticky64),
`endif
    .out_tag(out_tag64)
  );

  // Reference decoder: field arithmetic on the instruction value, sign applied by range folding
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] tag);
    exp_t   e;
    longint x, v, f3, opc;
    x = longint'({32'b0, inst});
    opc = x % 128;
    f3 = (x >> 12) % 8;
    v = (x >> 20);
    if (v >= 2048) v -= 4096;
    e.imm64 = 0;
    e.fmt = FMT_NONE;
    e.ill = 1'b0;
    e.tag = tag;
    case (opc)
      3, 103, 115: begin e.fmt = FMT_I; e.imm64 = v; end
      19, 27: begin
        if (f3 == 1 || f3 == 5) begin
          e.fmt = FMT_SHAMT;
          e.imm64 = (opc == 19) ? (x >> 20) % 64 : (x >> 20) % 32;
        end else begin
          e.fmt = FMT_I;
          e.imm64 = v;
        end
      end
      35: begin
        e.fmt = FMT_S;
        v = (x >> 25) * 32 + (x >> 7) % 32;
        if (v >= 2048) v -= 4096;
        e.imm64 = v;
      end
      99: begin
        e.fmt = FMT_B;
        v = ((x >> 31) % 2) * 4096 + ((x >> 7) % 2) * 2048 + ((x >> 25) % 64) * 32 + ((x >> 8) % 16) * 2;
        if (v >= 4096) v -= 8192;
        e.imm64 = v;
      end
      55, 23: begin
        e.fmt = FMT_U;
        v = (x / 4096) * 4096;
        if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
        e.imm64 = v;
      end
      111: begin
        e.fmt = FMT_J;
        v = ((x >> 31) % 2) * (longint'(1) << 20) + ((x >> 12) % 256) * 4096
            + ((x >> 20) % 2) * 2048 + ((x >> 21) % 1024) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
        e.imm64 = v;
      end
      default: e.ill = 1'b1;
    endcase
    if (x % 4 != 3) e.ill = 1'b1;
    e.imm32 = e.imm64[31:0];
    // XLEN=32 shift amounts are only five bits wide
    if (e.fmt == FMT_SHAMT) e.imm32 = 32'((x >> 20) % 32);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One clock: settle the scoreboard for this edge's handshakes, step, then compare state
  task automatic tick();
    bit acc, drn;
    acc = in_valid && in_ready32 && !flush;
    drn = out_valid32 && out_ready;
    if (drn) begin
      if (sb.size() == 0) begin
        check("drain_unexpected", 64'(out_valid32), 64'(0));
      end else begin
        check("drain_imm32", 64'(out_imm32), 64'(sb[0].imm32));
        check("drain_imm64", out_imm64, sb[0].imm64);
        check("drain_fmt32", 64'(out_fmt32), 64'(sb[0].fmt));
        check("drain_fmt64", 64'(out_fmt64), 64'(sb[0].fmt));
        check("drain_tag64", 64'(out_tag64), 64'(sb[0].tag));
`ifdef IMM_DECODE_ILLEGAL_EN
        check("drain_ill32", 64'(out_illegal32), 64'(sb[0].ill));
        check("drain_ill64", 64'(out_illegal64), 64'(sb[0].ill));
`endif
        drained.push_back(out_tag32);
        void'(sb.pop_front());
      end
    end
    if (flush) begin
      sb.delete();
    end else if (acc) begin
      sb.push_back(model(in_inst, in_tag));
      if (sb[$].ill) sticky_exp = 1'b1;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    check("out_valid32", 64'(out_valid32), 64'(sb.size() != 0));
    check("out_valid64", 64'(out_valid64), 64'(sb.size() != 0));
    check("in_ready32", 64'(in_ready32), 64'(sb.size() < 2));
    check("in_ready64", 64'(in_ready64), 64'(sb.size() < 2));
    if (sb.size() != 0) begin
      check("front_tag32", 64'(out_tag32), 64'(sb[0].tag));
      check("front_imm32", 64'(out_imm32), 64'(sb[0].imm32));
    end
`ifdef IMM_DECODE_ILLEGAL_EN
    check("err_sticky32", 64'(err_sticky32), 64'(sticky_exp));
    check("err_sticky64", 64'(err_sticky64), 64'(sticky_exp));
`endif
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, 64'(out_valid32), 64'(0));
    check({name, "_ready"}, 64'(in_ready32), 64'(1));
    check({name, "_imm32"}, 64'(out_imm32), 64'(0));
    check({name, "_imm64"}, out_imm64, 64'(0));
    check({name, "_fmt"}, 64'(out_fmt32), 64'(FMT_NONE));
    check({name, "_tag"}, 64'(out_tag32), 64'(0));
`ifdef IMM_DECODE_ILLEGAL_EN
    check({name, "_ill"}, 64'(out_illegal32), 64'(0));
    check({name, "_sticky"}, 64'(err_sticky32), 64'(0));
`endif
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [12];
    logic [31:0] r;
    opcs = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_LUI,
             OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, 7'b0110011, 7'b0};
    r = $urandom();
    opcs[11] = 7'($urandom());
    return {r[31:7], opcs[$urandom_range(11, 0)]};
  endfunction

  // Push one instruction with out_ready high and compare the next-cycle result to a constant
  task automatic send_const(input logic [31:0] inst, input logic [31:0] tag, input string name,
                            input logic [63:0] exp_imm, input bit use64, input imm_fmt_e exp_fmt);
    in_valid = 1'b1;
    in_inst = inst;
    in_tag = tag;
    tick();
    check({name, "_acc"}, 64'(last_acc), 64'(1));
    if (use64) check({name, "_imm"}, out_imm64, exp_imm);
    else       check({name, "_imm"}, 64'(out_imm32), exp_imm);
    check({name, "_fmt"}, 64'(out_fmt32), 64'(exp_fmt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sticky_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst_n = 1'b1;
    #1;
    check_reset_values("rst_rel");
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send_const(32'hFFF00093, 32'd1, "addi", 64'hFFFFFFFF, 1'b0, FMT_I);
    send_const(32'hFE000EE3, 32'd2, "beq", 64'hFFFFFFFC, 1'b0, FMT_B);
    send_const(32'h0080006F, 32'd3, "jal", 64'h00000008, 1'b0, FMT_J);
    send_const(32'h123450B7, 32'd4, "lui", 64'h12345000, 1'b0, FMT_U);
    send_const(32'h4030D093, 32'd5, "srai3", 64'h00000003, 1'b0, FMT_SHAMT);
    send_const(32'h800000B7, 32'd6, "lui64", 64'hFFFFFFFF80000000, 1'b1, FMT_U);
    send_const(32'h43F0D093, 32'd7, "srai63", 64'd63, 1'b1, FMT_SHAMT);
    in_valid = 1'b0;
    tick();

    // Backpressure: three pushes against a stalled consumer
    out_ready = 1'b0;
    drained.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_inst = rand_inst();
      in_tag = 32'd100 + 32'(k);
      tick();
      if (k < 2) check("bp_accept", 64'(last_acc), 64'(1));
    end
    check("bp_third_refused", 64'(last_acc), 64'(0));
    check("bp_ready_low", 64'(in_ready32), 64'(0));
    tick();
    check("bp_stable_tag", 64'(out_tag32), 64'(100));
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    check("bp_third_accept", 64'(last_acc), 64'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check("bp_drain_count", 64'(drained.size()), 64'(3));
    for (int k = 0; k < 3 && k < drained.size(); k++)
      check("bp_drain_order", 64'(drained[k]), 64'(100 + k));

    // Flush with two entries plus a same-cycle input
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_inst = rand_inst();
      in_tag = 32'd200 + 32'(k);
      tick();
    end
    in_tag = 32'd202;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid32), 64'(0));
    check("flush_ready", 64'(in_ready32), 64'(1));
    out_ready = 1'b1;
    drained.delete();
    repeat (3) tick();
    check("flush_nothing_out", 64'(drained.size()), 64'(0));

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(99, 0) < 70);
      in_inst = rand_inst();
      in_tag = $urandom();
      out_ready = ($urandom_range(99, 0) < 60);
      flush = ($urandom_range(99, 0) < 3);
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset while full
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_inst = rand_inst();
      in_tag = 32'd300 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    sticky_exp = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("post_rst");

    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h00000000;
    in_tag = 32'd400;
    tick();
    in_valid = 1'b0;
    check("zero_inst_fmt", 64'(out_fmt32), 64'(FMT_NONE));
    check("zero_inst_imm", 64'(out_imm32), 64'(0));
`ifdef IMM_DECODE_ILLEGAL_EN
    check("zero_inst_illegal", 64'(out_illegal32), 64'(1));
    check("zero_inst_sticky", 64'(err_sticky32), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("sticky_after_flush", 64'(err_sticky32), 64'(1));
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
